// File: rtl/vae_ctrl_pkg.sv
// Shared definitions for the VAE inference sequencer.
// Holds the layer geometry, the decoder base offsets into the flat weight and
// bias memories, the index widths, the activation select codes and the
// sequencer state enum.
package vae_ctrl_pkg;

   localparam int N_input_enc  = 9;
   localparam int M_output_enc = 4;
   localparam int N_input_dec  = 2;
   localparam int M_output_dec = 9;

   // Decoder weights/biases follow the encoder ones in the flat memories
   localparam int W_DEC_BASE = N_input_enc * M_output_enc;
   localparam int B_DEC_BASE = M_output_enc;

   localparam int W_ADDR_W = 6;
   localparam int B_ADDR_W = 4;
   localparam int IDX_W    = 4;
   localparam int ACT_W    = 2;

   localparam logic [ACT_W-1:0] ACT_PASS     = 2'b00;
   localparam logic [ACT_W-1:0] ACT_SOFTPLUS = 2'b01;
   localparam logic [ACT_W-1:0] ACT_SIGMOID  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MAC,
      ST_DRAIN,
      ST_BIAS,
      ST_WB,
      ST_SAMPLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/vae_layer_iter.sv
// Operand, drain and neuron counters for one layer pass of the shared datapath.
// Reused for both layers: the current operand count n and neuron count m are
// inputs, so the same counters walk the encoder and then the decoder.
//   clk, rst      : clock, synchronous active-high reset
//   n, m          : operands per neuron / neurons in the current layer
//   k_step        : advance operand counter (wraps to 0 after n-1)
//   drain_step    : advance drain counter (wraps to 0 after MAC_LAT-1)
//   neuron_step   : advance neuron counter
//   neuron_clr    : clear neuron counter (takes priority over neuron_step)
//   k, neuron     : current operand / neuron index
//   last_k, last_drain, last_neuron : final value of each counter reached
module vae_layer_iter
   import vae_ctrl_pkg::*;
#(
   parameter int MAC_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] n,
   input  logic [IDX_W-1:0] m,
   input  logic             k_step,
   input  logic             drain_step,
   input  logic             neuron_step,
   input  logic             neuron_clr,
   output logic [IDX_W-1:0] k,
   output logic [IDX_W-1:0] neuron,
   output logic             last_k,
   output logic             last_drain,
   output logic             last_neuron
);

   localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   // With MAC_LAT = 0 the drain counter exists but is never stepped
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

   logic [DRAIN_W-1:0] drain;

   assign last_k      = (k == n - IDX_W'(1));
   assign last_drain  = (drain == DRAIN_LAST);
   assign last_neuron = (neuron == m - IDX_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         k      <= '0;
         drain  <= '0;
         neuron <= '0;
      end else begin
         if (k_step)
            k <= last_k ? '0 : k + IDX_W'(1);
         if (drain_step)
            drain <= last_drain ? '0 : drain + DRAIN_W'(1);
         if (neuron_clr)
            neuron <= '0;
         else if (neuron_step)
            neuron <= neuron + IDX_W'(1);
      end
   end

endmodule

// File: rtl/vae_seq_ctrl.sv
// Sequencer for a time-multiplexed VAE datapath. Walks one shared
// MAC/bias/activation/result-buffer datapath through encoder layer (softplus on
// variance outputs), sampling step, decoder layer and sigmoid.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input vector handshake; x_load pulses on acceptance
//   out_valid/out_ready : result handshake once the 9 sigmoid outputs are stored
//   busy, layer         : not idle / 0 encoder, 1 decoder
//   w_addr, b_addr      : flat weight / bias indices
//   x_idx               : operand index within the current layer input
//   mac_en, acc_clr     : MAC accumulate / load-instead-of-add strobes
//   bias_add            : add bias[b_addr] to the accumulator
//   act_sel, res_we, res_idx : activation select and result write
//   samp_en             : latent sampling strobe
module vae_seq_ctrl
   import vae_ctrl_pkg::*;
#(
   parameter int MAC_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                x_load,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                layer,
   output logic [W_ADDR_W-1:0] w_addr,
   output logic [B_ADDR_W-1:0] b_addr,
   output logic [IDX_W-1:0]    x_idx,
   output logic                mac_en,
   output logic                acc_clr,
   output logic                bias_add,
   output logic [ACT_W-1:0]    act_sel,
   output logic                res_we,
   output logic [IDX_W-1:0]    res_idx,
   output logic                samp_en
);

   state_t           state, state_nxt;
   logic             layer_set, layer_clr;
   logic             k_step, drain_step, neuron_step, neuron_clr;
   logic [IDX_W-1:0] n_cur, m_cur, k, neuron;
   logic             last_k, last_drain, last_neuron;

   assign n_cur = layer ? IDX_W'(N_input_dec)  : IDX_W'(N_input_enc);
   assign m_cur = layer ? IDX_W'(M_output_dec) : IDX_W'(M_output_enc);

   vae_layer_iter #(.MAC_LAT(MAC_LAT)) u_iter (
      .clk         (clk),
      .rst         (rst),
      .n           (n_cur),
      .m           (m_cur),
      .k_step      (k_step),
      .drain_step  (drain_step),
      .neuron_step (neuron_step),
      .neuron_clr  (neuron_clr),
      .k           (k),
      .neuron      (neuron),
      .last_k      (last_k),
      .last_drain  (last_drain),
      .last_neuron (last_neuron)
   );

   // in_ready is held low while rst is asserted, even if already idle
   assign in_ready = (state == ST_IDLE) && !rst;
   assign x_load   = in_valid && in_ready;
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         layer <= 1'b0;
      end else begin
         state <= state_nxt;
         if (layer_clr)
            layer <= 1'b0;
         else if (layer_set)
            layer <= 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      layer_set   = 1'b0;
      layer_clr   = 1'b0;
      k_step      = 1'b0;
      drain_step  = 1'b0;
      neuron_step = 1'b0;
      neuron_clr  = 1'b0;
      out_valid   = 1'b0;
      w_addr      = '0;
      b_addr      = '0;
      x_idx       = '0;
      mac_en      = 1'b0;
      acc_clr     = 1'b0;
      bias_add    = 1'b0;
      act_sel     = ACT_PASS;
      res_we      = 1'b0;
      res_idx     = '0;
      samp_en     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (x_load)
               state_nxt = ST_MAC;
         end
         ST_MAC: begin
            mac_en  = 1'b1;
            acc_clr = (k == '0);
            x_idx   = k;
            w_addr  = (layer ? W_ADDR_W'(W_DEC_BASE) : '0)
                    + W_ADDR_W'(neuron) * W_ADDR_W'(n_cur) + W_ADDR_W'(k);
            k_step  = 1'b1;
            if (last_k)
               state_nxt = (MAC_LAT == 0) ? ST_BIAS : ST_DRAIN;
         end
         ST_DRAIN: begin
            drain_step = 1'b1;
            if (last_drain)
               state_nxt = ST_BIAS;
         end
         ST_BIAS: begin
            bias_add  = 1'b1;
            b_addr    = (layer ? B_ADDR_W'(B_DEC_BASE) : '0) + B_ADDR_W'(neuron);
            state_nxt = ST_WB;
         end
         ST_WB: begin
            res_we  = 1'b1;
            res_idx = neuron;
            // Odd encoder outputs carry the variance terms
            if (layer)
               act_sel = ACT_SIGMOID;
            else
               act_sel = neuron[0] ? ACT_SOFTPLUS : ACT_PASS;
            if (!last_neuron) begin
               neuron_step = 1'b1;
               state_nxt   = ST_MAC;
            end else begin
               state_nxt = layer ? ST_DONE : ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            samp_en    = 1'b1;
            layer_set  = 1'b1;
            neuron_clr = 1'b1;
            state_nxt  = ST_MAC;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               layer_clr  = 1'b1;
               neuron_clr = 1'b1;
               state_nxt  = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
